// File: rtl/sv_dma_mc.sv
// Multi-channel CPU-bus <-> VRAM-bus DMA engine with per-channel registers,
// block-granular round-robin arbitration and LCD fetch-slot yielding.
module sv_dma_mc #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CADDR_W = 16,
  parameter int unsigned VADDR_W = 13,
  parameter int unsigned BLOCK   = 16,
  parameter int unsigned LCD_DIV = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [5:0]         ab,
  input  logic               cpu_rnw,
  input  logic               dma_cs,
  input  logic               lcd_en,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic [CADDR_W-1:0] cbus_addr,
  output logic [VADDR_W-1:0] vbus_addr,
  output logic               dma_dir,
  output logic               dma_en,
  output logic [1:0]         dma_ch,
  output logic               irq
);

  localparam int unsigned PW = $clog2(BLOCK);
  localparam int unsigned LW = (LCD_DIV > 1) ? $clog2(LCD_DIV) : 1;
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PW-1:0] PHASE_INIT = PW'(BLOCK - 1);
  localparam logic [LW-1:0] DIV_LAST   = LW'(LCD_DIV - 1);

  logic [CADDR_W-1:0] cbus_q  [NCH];
  logic [CADDR_W-1:0] cbus_d  [NCH];
  logic [VADDR_W-1:0] vbus_q  [NCH];
  logic [VADDR_W-1:0] vbus_d  [NCH];
  logic [7:0]         len_q   [NCH];
  logic [7:0]         len_d   [NCH];
  logic [8:0]         blk_q   [NCH];
  logic [8:0]         blk_d   [NCH];
  logic [PW-1:0]      phase_q [NCH];
  logic [PW-1:0]      phase_d [NCH];
  logic [NCH-1:0]     busy_q, busy_d, done_q, done_d, ien_q, ien_d, dir_q, dir_d;
  logic [LW-1:0]      lcd_div_q, lcd_div_d;
  logic [GW-1:0]      gnt_q, gnt_d, scan;
  logic               lcd_stall, blk_end, wr_en, found;

  assign lcd_stall = lcd_en & (lcd_div_q == DIV_LAST);
  assign dma_en    = busy_q[gnt_q] & ~lcd_stall;
  assign blk_end   = dma_en & (phase_q[gnt_q] == '0);
  assign wr_en     = dma_cs & ~cpu_rnw;

  assign cbus_addr = cbus_q[gnt_q];
  assign vbus_addr = vbus_q[gnt_q];
  assign dma_dir   = dir_q[gnt_q];
  assign dma_ch    = 2'(gnt_q);
  assign irq       = |(done_q & ien_q);

  always_comb begin
    data_out = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (ab[5:3] == 3'(c + 1)) begin
        case (ab[2:0])
          3'd0:    data_out = 8'(cbus_q[c]);
          3'd1:    data_out = 8'(cbus_q[c] >> 8);
          3'd2:    data_out = 8'(vbus_q[c]);
          3'd3:    data_out = {1'b0, dir_q[c], 1'b0, 5'(vbus_q[c] >> 8)};
          3'd4:    data_out = len_q[c];
          3'd5:    data_out = {busy_q[c], ien_q[c], 5'b0, done_q[c]};
          3'd6:    data_out = {7'b0, done_q[c]};
          default: data_out = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    cbus_d    = cbus_q;
    vbus_d    = vbus_q;
    len_d     = len_q;
    blk_d     = blk_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ien_d     = ien_q;
    dir_d     = dir_q;
    gnt_d     = gnt_q;
    scan      = gnt_q;
    found     = 1'b0;
    lcd_div_d = (lcd_div_q == DIV_LAST) ? '0 : lcd_div_q + LW'(1);

    // Register writes go first so a completion below overrides a done clear.
    for (int c = 0; c < NCH; c++) begin
      if (wr_en && ab[5:3] == 3'(c + 1)) begin
        case (ab[2:0])
          3'd0: if (!busy_q[c]) cbus_d[c] = CADDR_W'({8'(cbus_q[c] >> 8), data_in});
          3'd1: if (!busy_q[c]) cbus_d[c] = CADDR_W'({data_in, 8'(cbus_q[c])});
          3'd2: if (!busy_q[c]) vbus_d[c] = VADDR_W'({8'(vbus_q[c] >> 8), data_in});
          3'd3: begin
            if (!busy_q[c]) begin
              vbus_d[c] = VADDR_W'({3'b0, data_in[4:0], 8'(vbus_q[c])});
              dir_d[c]  = data_in[6];
            end
          end
          3'd4: if (!busy_q[c]) len_d[c] = data_in;
          3'd5: begin
            ien_d[c] = data_in[6];
            if (data_in[0]) begin
              busy_d[c] = 1'b0;
            end else if (data_in[7] && !busy_q[c]) begin
              busy_d[c]  = 1'b1;
              done_d[c]  = 1'b0;
              blk_d[c]   = {len_q[c] == 8'h00, len_q[c]};
              phase_d[c] = PHASE_INIT;
            end
          end
          3'd6: if (data_in[0]) done_d[c] = 1'b0;
          default: ;
        endcase
      end
    end

    if (dma_en) begin
      cbus_d[gnt_q] = cbus_q[gnt_q] + CADDR_W'(1);
      vbus_d[gnt_q] = vbus_q[gnt_q] + VADDR_W'(1);
      if (phase_q[gnt_q] == '0) begin
        blk_d[gnt_q]   = blk_q[gnt_q] - 9'd1;
        phase_d[gnt_q] = PHASE_INIT;
        if (blk_q[gnt_q] == 9'd1) begin
          busy_d[gnt_q] = 1'b0;
          done_d[gnt_q] = 1'b1;
        end
      end else begin
        phase_d[gnt_q] = phase_q[gnt_q] - PW'(1);
      end
    end

    // Round-robin from gnt+1, wrapping back to gnt itself, on pre-edge busy.
    if (!busy_q[gnt_q] || blk_end) begin
      for (int i = 1; i <= NCH; i++) begin
        scan = GW'((int'(gnt_q) + i) % NCH);
        if (!found && busy_q[scan]) begin
          gnt_d = scan;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cbus_q    <= '{default: '0};
      vbus_q    <= '{default: '0};
      len_q     <= '{default: '0};
      blk_q     <= '{default: '0};
      phase_q   <= '{default: PHASE_INIT};
      busy_q    <= '0;
      done_q    <= '0;
      ien_q     <= '0;
      dir_q     <= '0;
      lcd_div_q <= '0;
      gnt_q     <= '0;
    end else if (ce) begin
      cbus_q    <= cbus_d;
      vbus_q    <= vbus_d;
      len_q     <= len_d;
      blk_q     <= blk_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ien_q     <= ien_d;
      dir_q     <= dir_d;
      lcd_div_q <= lcd_div_d;
      gnt_q     <= gnt_d;
    end
  end

endmodule
